// File: rtl/i2c_cmd_responder_pkg.sv
// ----------------------------------------------------------------------------
// i2c_cmd_responder_pkg
// Shared definitions for the on-chip I2C command responder: FSM state
// encodings, command-operation encodings, the value returned on reads to a
// device that is not present, and the flag-priority decode helper.
// ----------------------------------------------------------------------------
package i2c_cmd_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE_1    = 3'd1,
    ST_WRITE_MULT = 3'd2,
    ST_READ       = 3'd3,
    ST_DRAIN      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE       = 2'd0,
    OP_WRITE_MULT = 2'd1,
    OP_WRITE_1    = 2'd2,
    OP_READ       = 2'd3
  } op_t;

  // Value seen on a read from an absent device (bus pulled high).
  localparam logic [7:0] IDLE_BUS_BYTE = 8'hFF;

  // Resolve the command flags to one operation: write_multiple beats write,
  // write beats read; no flag means a stop-only / no-op command.
  function automatic op_t decode_op(input logic rd, input logic wr, input logic wm);
    op_t op;
    if (wm) begin
      op = OP_WRITE_MULT;
    end else if (wr) begin
      op = OP_WRITE_1;
    end else if (rd) begin
      op = OP_READ;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/i2c_cmd_responder_if.sv
// ----------------------------------------------------------------------------
// i2c_cmd_responder_if
// Command / write-data / read-data handshake bundle between an I2C command
// generator (master modport) and the responder (slave modport).
//   cmd_*          : command fields, cmd_valid/cmd_ready handshake
//   data_in*       : write-data stream toward the target
//   data_out*      : read-data stream back to the command generator
// ----------------------------------------------------------------------------
interface i2c_cmd_responder_if;
  logic [6:0] cmd_address;
  logic       cmd_start;
  logic       cmd_read;
  logic       cmd_write;
  logic       cmd_write_multiple;
  logic       cmd_stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       data_in_last;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  modport master (
    output cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
           cmd_stop, cmd_valid, data_in, data_in_valid, data_in_last,
           data_out_ready,
    input  cmd_ready, data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple,
           cmd_stop, cmd_valid, data_in, data_in_valid, data_in_last,
           data_out_ready,
    output cmd_ready, data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/i2c_cmd_responder_regs.sv
// ----------------------------------------------------------------------------
// i2c_cmd_responder_regs
// DEPTH x 8-bit register file with a register pointer that auto-increments
// and wraps modulo DEPTH.
//   clk, rst_n : clock, asynchronous active-low reset
//   ptr_load   : load pointer from the low bits of wr_data
//   wr_en      : write wr_data to reg[ptr], then advance pointer
//   ptr_inc    : advance pointer (read consumed)
//   wr_data    : write / pointer-load byte
//   rd_data    : reg[ptr] (combinational read mux)
//   reg_file   : all registers flattened, reg k at [8k+7:8k]
// ----------------------------------------------------------------------------
module i2c_cmd_responder_regs #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ptr_load,
  input  logic               wr_en,
  input  logic               ptr_inc,
  input  logic [7:0]         wr_data,
  output logic [7:0]         rd_data,
  output logic [DEPTH*8-1:0] reg_file
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] ptr_r;

  // Pointer: load from first byte, otherwise step on each write or read.
  // DEPTH is a power of two, so natural overflow gives the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (ptr_load) begin
      ptr_r <= wr_data[PTR_W-1:0];
    end else if (wr_en || ptr_inc) begin
      ptr_r <= ptr_r + PTR_ONE;
    end
  end

  // Register array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= 8'h00;
      end
    end else if (wr_en) begin
      mem_r[ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[ptr_r];

  // Flatten the array onto the observation bus.
  always_comb begin
    reg_file = {(DEPTH*8){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      reg_file[k*8 +: 8] = mem_r[k];
    end
  end

endmodule

// File: rtl/i2c_cmd_responder.sv
// ----------------------------------------------------------------------------
// i2c_cmd_responder
// Bus-less I2C register-pointer target. Consumes the i2c_master command and
// data handshakes, decodes transfers (first written byte = pointer, further
// bytes write/read registers with auto-increment) against a local register
// file, and answers only to DEV_ADDR.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command / write-data / read-data handshakes (slave side)
//   reg_file   : register contents, reg k at [8k+7:8k]
//   busy       : high while a command's data phase is in progress
//   nack       : one-cycle pulse when a command for another device is accepted
// ----------------------------------------------------------------------------
module i2c_cmd_responder
  import i2c_cmd_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         DEPTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i2c_cmd_responder_if.slave   bus,
  output logic [DEPTH*8-1:0]   reg_file,
  output logic                 busy,
  output logic                 nack
);

  localparam int PTR_W = $clog2(DEPTH);

  state_t     state_r;
  state_t     next_state_s;
  op_t        op_s;

  logic       cmd_ready_r;
  logic       data_in_ready_r;
  logic       data_out_valid_r;
  logic [7:0] data_out_r;
  logic       busy_r;

  // Open-transfer tracking.
  logic       xfer_open_r;
  logic [6:0] xfer_addr_r;
  logic       xfer_write_r;
  logic       first_byte_r;

  // Attributes of the command currently in its data phase.
  logic       match_r;
  logic       stop_r;
  logic       mult_r;

  logic       accept_s;
  logic       match_s;
  logic       is_write_s;
  logic       has_data_s;
  logic       new_xfer_s;
  logic       in_hs_s;
  logic       out_hs_s;
  logic       done_s;
  logic       ptr_load_s;
  logic       wr_en_s;
  logic       ptr_inc_s;
  logic [7:0] rd_data_s;

  assign op_s       = decode_op(bus.cmd_read, bus.cmd_write, bus.cmd_write_multiple);
  assign accept_s   = bus.cmd_valid && cmd_ready_r;
  assign match_s    = (bus.cmd_address == DEV_ADDR);
  assign is_write_s = (op_s == OP_WRITE_MULT) || (op_s == OP_WRITE_1);
  assign has_data_s = (op_s != OP_NONE);
  assign in_hs_s    = bus.data_in_valid && data_in_ready_r;
  assign out_hs_s   = data_out_valid_r && bus.data_out_ready;
  assign done_s     = (state_r != ST_IDLE) && (next_state_s == ST_IDLE);

  // A write starts a fresh transfer (pointer byte expected) unless it
  // continues an open write to the same device without a start flag.
  assign new_xfer_s = bus.cmd_start || !xfer_open_r ||
                      (bus.cmd_address != xfer_addr_r) ||
                      (!xfer_write_r && is_write_s);

  // nack is flagged in the accept cycle itself.
  assign nack = accept_s && has_data_s && !match_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (op_s)
            OP_WRITE_MULT: next_state_s = match_s ? ST_WRITE_MULT : ST_DRAIN;
            OP_WRITE_1:    next_state_s = match_s ? ST_WRITE_1 : ST_DRAIN;
            OP_READ:       next_state_s = ST_READ;
            default:       next_state_s = ST_IDLE;
          endcase
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WRITE_1: begin
        // data_in_last is irrelevant here: a single write takes one byte.
        if (in_hs_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WRITE_1;
        end
      end
      ST_WRITE_MULT: begin
        if (in_hs_s && bus.data_in_last) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WRITE_MULT;
        end
      end
      ST_READ: begin
        if (out_hs_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (in_hs_s && (!mult_r || bus.data_in_last)) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Register-file control strobes derived from the current data handshake.
  always_comb begin
    ptr_load_s = 1'b0;
    wr_en_s    = 1'b0;
    ptr_inc_s  = 1'b0;
    if (in_hs_s && ((state_r == ST_WRITE_1) || (state_r == ST_WRITE_MULT))) begin
      if (first_byte_r) begin
        ptr_load_s = 1'b1;
      end else begin
        wr_en_s = 1'b1;
      end
    end else if (out_hs_s && (state_r == ST_READ) && match_r) begin
      ptr_inc_s = 1'b1;
    end else begin
      ptr_load_s = 1'b0;
    end
  end

  // Transfer tracking: open/close, target address, direction, first byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_open_r  <= 1'b0;
      xfer_addr_r  <= 7'h00;
      xfer_write_r <= 1'b0;
      first_byte_r <= 1'b0;
      match_r      <= 1'b0;
      stop_r       <= 1'b0;
      mult_r       <= 1'b0;
    end else if (accept_s) begin
      match_r <= match_s;
      stop_r  <= bus.cmd_stop;
      mult_r  <= (op_s == OP_WRITE_MULT);
      if (has_data_s) begin
        xfer_open_r  <= 1'b1;
        xfer_addr_r  <= bus.cmd_address;
        xfer_write_r <= is_write_s;
        if (is_write_s) begin
          if (new_xfer_s) begin
            first_byte_r <= 1'b1;
          end
        end else begin
          // Read after write is a repeated start: pointer already set.
          first_byte_r <= 1'b0;
        end
      end else if (bus.cmd_stop) begin
        xfer_open_r <= 1'b0;
      end
    end else begin
      if (done_s && stop_r) begin
        xfer_open_r <= 1'b0;
      end
      if (ptr_load_s) begin
        first_byte_r <= 1'b0;
      end
    end
  end

  // Handshake and status outputs. cmd_ready lags the return to IDLE by one
  // cycle, giving a three-cycle minimum command-to-command spacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_r     <= 1'b0;
      data_in_ready_r <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      cmd_ready_r     <= (state_r == ST_IDLE) && !accept_s;
      data_in_ready_r <= (next_state_s == ST_WRITE_1) ||
                         (next_state_s == ST_WRITE_MULT) ||
                         (next_state_s == ST_DRAIN);
      busy_r          <= (next_state_s != ST_IDLE);
    end
  end

  // Read data: captured at command accept and held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_valid_r <= 1'b0;
      data_out_r       <= 8'h00;
    end else if (accept_s && (op_s == OP_READ)) begin
      data_out_valid_r <= 1'b1;
      data_out_r       <= match_s ? rd_data_s : IDLE_BUS_BYTE;
    end else if (out_hs_s) begin
      data_out_valid_r <= 1'b0;
      data_out_r       <= 8'h00;
    end
  end

  i2c_cmd_responder_regs #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .ptr_load (ptr_load_s),
    .wr_en    (wr_en_s),
    .ptr_inc  (ptr_inc_s),
    .wr_data  (bus.data_in),
    .rd_data  (rd_data_s),
    .reg_file (reg_file)
  );

  assign bus.cmd_ready      = cmd_ready_r;
  assign bus.data_in_ready  = data_in_ready_r;
  assign bus.data_out_valid = data_out_valid_r;
  assign bus.data_out       = data_out_r;
  assign busy               = busy_r;

endmodule

// File: tb/tb_i2c_cmd_responder.sv
// ----------------------------------------------------------------------------
// tb_i2c_cmd_responder
// Directed self-checking bench for i2c_cmd_responder (DEV_ADDR=0x50, DEPTH=16).
// ----------------------------------------------------------------------------
module tb_i2c_cmd_responder;

  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [DEPTH*8-1:0] reg_file;
  logic               busy;
  logic               nack;

  int n_cmp = 0;
  int n_bad = 0;
  int nack_cycles = 0;
  int ready_busy_viol = 0;

  logic [7:0] exp_mem [DEPTH];

  i2c_cmd_responder_if ifc ();

  i2c_cmd_responder #(.DEV_ADDR(7'h50), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .reg_file (reg_file),
    .busy     (busy),
    .nack     (nack)
  );

  always #5 clk = ~clk;

  // Observe nack pulses and cmd_ready/busy overlap mid-cycle.
  always @(negedge clk) begin
    if (nack === 1'b1) nack_cycles++;
    if (ifc.cmd_ready === 1'b1 && busy === 1'b1) ready_busy_viol++;
  end

  function automatic logic [DEPTH*8-1:0] exp_rf();
    logic [DEPTH*8-1:0] v;
    for (int k = 0; k < DEPTH; k++) v[k*8 +: 8] = exp_mem[k];
    return v;
  endfunction

  task automatic clear_exp();
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = 8'h00;
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic init_bus();
    ifc.cmd_address = 7'h00; ifc.cmd_start = 1'b0; ifc.cmd_read = 1'b0;
    ifc.cmd_write = 1'b0; ifc.cmd_write_multiple = 1'b0; ifc.cmd_stop = 1'b0;
    ifc.cmd_valid = 1'b0; ifc.data_in = 8'h00; ifc.data_in_valid = 1'b0;
    ifc.data_in_last = 1'b0; ifc.data_out_ready = 1'b0;
  endtask

  // Present a command and wait (bounded) for its handshake.
  task automatic send_cmd(input logic [6:0] addr, input logic st, input logic rd,
                          input logic wr, input logic wm, input logic sp, input bit keep_valid);
    int n = 0;
    ifc.cmd_address = addr; ifc.cmd_start = st; ifc.cmd_read = rd;
    ifc.cmd_write = wr; ifc.cmd_write_multiple = wm; ifc.cmd_stop = sp;
    ifc.cmd_valid = 1'b1;
    while (ifc.cmd_ready !== 1'b1 && n < 50) begin wait_edge(); n++; end
    if (ifc.cmd_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_timeout: cmd_ready=%b required 1", ifc.cmd_ready);
    end else begin
      wait_edge();
    end
    if (!keep_valid) ifc.cmd_valid = 1'b0;
  endtask

  // Present one write byte and wait (bounded) for its handshake.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    ifc.data_in = d; ifc.data_in_last = last; ifc.data_in_valid = 1'b1;
    while (ifc.data_in_ready !== 1'b1 && n < 50) begin wait_edge(); n++; end
    if (ifc.data_in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL data_timeout: data_in_ready=%b required 1", ifc.data_in_ready);
    end else begin
      wait_edge();
    end
    ifc.data_in_valid = 1'b0; ifc.data_in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ifc.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 0", ifc.cmd_ready); end
    n_cmp++; if (ifc.data_in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_din_ready: got %b want 0", ifc.data_in_ready); end
    n_cmp++; if (ifc.data_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dout_valid: got %b want 0", ifc.data_out_valid); end
    n_cmp++; if (ifc.data_out !== 8'h00) begin n_bad++; $display("FAIL rst_dout: got %h want 00", ifc.data_out); end
    n_cmp++; if (busy !== 1'b0 || nack !== 1'b0) begin n_bad++; $display("FAIL rst_busy_nack: got %b%b want 00", busy, nack); end
    n_cmp++; if (reg_file !== exp_rf()) begin n_bad++; $display("FAIL rst_regfile: got %h want %h", reg_file, exp_rf()); end
    rst_n = 1'b1;
    wait_edge();
    n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_cmd_ready: got %b want 1", ifc.cmd_ready); end
    // Reset in the middle of a write_multiple.
    send_cmd(7'h50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h77, 1'b0);
    n_cmp++; if (reg_file[23:16] !== 8'h77) begin n_bad++; $display("FAIL mid_reg2: got %h want 77", reg_file[23:16]); end
    n_cmp++; if (busy !== 1'b1 || ifc.data_in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b%b want 11", busy, ifc.data_in_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || ifc.data_in_ready !== 1'b0 || ifc.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL async_rst: got busy=%b din_rdy=%b cmd_rdy=%b want 000", busy, ifc.data_in_ready, ifc.cmd_ready); end
    n_cmp++; if (reg_file !== exp_rf()) begin n_bad++; $display("FAIL async_rst_regfile: got %h want %h", reg_file, exp_rf()); end
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h0) begin n_bad++; $display("FAIL async_rst_ptr: got %h want 0", dut.u_regs.ptr_r); end
    wait_edge();
    rst_n = 1'b1;
    n_cmp++; if (ifc.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rel2_cmd_ready_early: got %b want 0", ifc.cmd_ready); end
    wait_edge();
    n_cmp++; if (ifc.cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rel2_cmd_ready: got rdy=%b busy=%b want 1 0", ifc.cmd_ready, busy); end
  endtask

  task automatic test_idle_data();
    ifc.data_in = 8'h09; ifc.data_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ifc.data_in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_din_ready: got %b want 0", ifc.data_in_ready); end
      wait_edge();
    end
    ifc.data_in_valid = 1'b0;
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h0) begin n_bad++; $display("FAIL idle_ptr: got %h want 0", dut.u_regs.ptr_r); end
  endtask

  task automatic test_write_mult();
    int n0 = nack_cycles;
    send_cmd(7'h50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    exp_mem[3] = 8'hAA; exp_mem[4] = 8'hBB;
    n_cmp++; if (reg_file !== exp_rf()) begin n_bad++; $display("FAIL wm_regfile: got %h want %h", reg_file, exp_rf()); end
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h5) begin n_bad++; $display("FAIL wm_ptr: got %h want 5", dut.u_regs.ptr_r); end
    n_cmp++; if (nack_cycles - n0 !== 0) begin n_bad++; $display("FAIL wm_nack: got %0d pulses want 0", nack_cycles - n0); end
    n_cmp++; if (busy !== 1'b0 || ifc.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL wm_idle_lag: got busy=%b rdy=%b want 0 0", busy, ifc.cmd_ready); end
    wait_edge();
    n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wm_cmd_ready: got %b want 1", ifc.cmd_ready); end
  endtask

  task automatic test_wrap();
    send_cmd(7'h50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h0F, 1'b1);
    n_cmp++; if (dut.u_regs.ptr_r !== 4'hF) begin n_bad++; $display("FAIL wrap_ptr_load: got %h want f", dut.u_regs.ptr_r); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wrap_w1_done: got busy=%b want 0", busy); end
    send_cmd(7'h50, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(8'hC1, 1'b0);
    n_cmp++; if (reg_file[127:120] !== 8'hC1 || dut.u_regs.ptr_r !== 4'h0) begin n_bad++; $display("FAIL wrap_reg15: got %h ptr %h want c1 ptr 0", reg_file[127:120], dut.u_regs.ptr_r); end
    send_byte(8'hC2, 1'b1);
    exp_mem[15] = 8'hC1; exp_mem[0] = 8'hC2;
    n_cmp++; if (reg_file !== exp_rf()) begin n_bad++; $display("FAIL wrap_regfile: got %h want %h", reg_file, exp_rf()); end
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h1) begin n_bad++; $display("FAIL wrap_ptr: got %h want 1", dut.u_regs.ptr_r); end
  endtask

  task automatic test_read_stall();
    send_cmd(7'h50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0);
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h3) begin n_bad++; $display("FAIL rd_ptr_set: got %h want 3", dut.u_regs.ptr_r); end
    send_cmd(7'h50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ifc.data_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (ifc.data_out_valid !== 1'b1 || ifc.data_out !== 8'hAA) begin n_bad++; $display("FAIL rd_hold: cycle %0d got v=%b d=%h want 1 aa", i, ifc.data_out_valid, ifc.data_out); end
      wait_edge();
    end
    ifc.data_out_ready = 1'b1;
    wait_edge();
    ifc.data_out_ready = 1'b0;
    n_cmp++; if (ifc.data_out_valid !== 1'b0) begin n_bad++; $display("FAIL rd_drop: got %b want 0", ifc.data_out_valid); end
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h4) begin n_bad++; $display("FAIL rd_ptr_inc: got %h want 4", dut.u_regs.ptr_r); end
    send_cmd(7'h50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (ifc.data_out_valid !== 1'b1 || ifc.data_out !== 8'hBB) begin n_bad++; $display("FAIL rd_second: got v=%b d=%h want 1 bb", ifc.data_out_valid, ifc.data_out); end
    ifc.data_out_ready = 1'b1;
    wait_edge();
    ifc.data_out_ready = 1'b0;
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h5 || busy !== 1'b0) begin n_bad++; $display("FAIL rd_end: got ptr %h busy %b want 5 0", dut.u_regs.ptr_r, busy); end
  endtask

  task automatic test_nack();
    int n0 = nack_cycles;
    send_cmd(7'h21, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (nack_cycles - n0 !== 1) begin n_bad++; $display("FAIL nack_wr_pulse: got %0d cycles want 1", nack_cycles - n0); end
    send_byte(8'h00, 1'b0);
    send_byte(8'h55, 1'b1);
    n_cmp++; if (reg_file !== exp_rf()) begin n_bad++; $display("FAIL nack_regfile: got %h want %h", reg_file, exp_rf()); end
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h5 || busy !== 1'b0) begin n_bad++; $display("FAIL nack_drain: got ptr %h busy %b want 5 0", dut.u_regs.ptr_r, busy); end
    send_cmd(7'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (nack_cycles - n0 !== 2) begin n_bad++; $display("FAIL nack_rd_pulse: got %0d cycles want 2", nack_cycles - n0); end
    n_cmp++; if (ifc.data_out_valid !== 1'b1 || ifc.data_out !== 8'hFF) begin n_bad++; $display("FAIL nack_rd_data: got v=%b d=%h want 1 ff", ifc.data_out_valid, ifc.data_out); end
    ifc.data_out_ready = 1'b1;
    wait_edge();
    ifc.data_out_ready = 1'b0;
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h5) begin n_bad++; $display("FAIL nack_rd_ptr: got %h want 5", dut.u_regs.ptr_r); end
  endtask

  task automatic test_back_to_back();
    int v0;
    int n0;
    rst_n = 1'b0;
    wait_edge();
    rst_n = 1'b1;
    wait_edge();
    clear_exp();
    v0 = ready_busy_viol;
    n0 = nack_cycles;
    send_cmd(7'h50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_byte(8'h01, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h12, 1'b1);
    send_cmd(7'h50, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_byte(8'h08, 1'b0); send_byte(8'h80, 1'b1);
    send_cmd(7'h50, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(8'h0E, 1'b1);
    send_cmd(7'h50, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_byte(8'hE1, 1'b0); send_byte(8'hE2, 1'b0); send_byte(8'hE3, 1'b1);
    ifc.cmd_valid = 1'b0;
    exp_mem[1] = 8'h11; exp_mem[2] = 8'h12; exp_mem[8] = 8'h80;
    exp_mem[14] = 8'hE1; exp_mem[15] = 8'hE2; exp_mem[0] = 8'hE3;
    wait_edge();
    n_cmp++; if (reg_file !== exp_rf()) begin n_bad++; $display("FAIL b2b_regfile: got %h want %h", reg_file, exp_rf()); end
    n_cmp++; if (dut.u_regs.ptr_r !== 4'h1) begin n_bad++; $display("FAIL b2b_ptr: got %h want 1", dut.u_regs.ptr_r); end
    n_cmp++; if (ready_busy_viol - v0 !== 0) begin n_bad++; $display("FAIL b2b_ready_busy: got %0d overlaps want 0", ready_busy_viol - v0); end
    n_cmp++; if (nack_cycles - n0 !== 0) begin n_bad++; $display("FAIL b2b_nack: got %0d pulses want 0", nack_cycles - n0); end
  endtask

  initial begin
    init_bus();
    clear_exp();
    test_reset();
    test_idle_data();
    test_write_mult();
    test_wrap();
    test_read_stall();
    test_nack();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
